dequant_zigzag_writer: RTL and testbench

Upstream stage of the IDCT engine. Accepts a handshaked stream of quantized DCT coefficients in zig-zag order from the lossless decoder. Dequantizes each coefficient by per-position left shift, reorders it to raster position, and writes it to the pre-IDCT SRAM region (76800–230399) in the block layout the IDCT stage reads. Blocks are written Y, then U, then V.

---
 rtl/dequant_zigzag_writer.sv | 174 +++++++++++++++++
 tb/tb_dequant_zigzag_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dequant_zigzag_writer.sv
// Dequantizes zig-zag ordered DCT coefficients and writes them in raster order to the pre-IDCT SRAM region.
// Optional DEQUANT_SAT_EN: saturate the shifted result to 16 bits instead of wrapping.
module dequant_zigzag_writer (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        quant_sel,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  input  logic [15:0] coeff_data,
  input  logic        coeff_eob,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        block_done,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZFILL, S_DONE} state_t;

  localparam logic [17:0] Y_BASE = 18'd76800;
  localparam logic [17:0] U_BASE = 18'd153600;
  localparam logic [17:0] V_BASE = 18'd192000;

  localparam logic [5:0] ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  function automatic logic [2:0] q0_shift(input logic [3:0] s);
    if (s == 4'd0)      return 3'd3;
    else if (s == 4'd1) return 3'd2;
    else if (s == 4'd2) return 3'd3;
    else if (s == 4'd3) return 3'd4;
    else if (s <= 4'd5) return 3'd5;
    else                return 3'd6;
  endfunction

  function automatic logic [2:0] q1_shift(input logic [3:0] s);
    if (s == 4'd0)      return 3'd3;
    else if (s <= 4'd3) return 3'd1;
    else if (s == 4'd4) return 3'd2;
    else if (s == 4'd5) return 3'd3;
    else if (s == 4'd6) return 3'd4;
    else                return 3'd5;
  endfunction

  state_t      state;
  logic [5:0]  k;
  logic [11:0] b;
  logic        q_sel;
  logic        is_y;
  logic [5:0]  bcol;
  logic [17:0] blk_base;
  logic [17:0] row_base;

  logic        issue, last;
  logic [5:0]  raster;
  logic [2:0]  row, col;
  logic [3:0]  diag;
  logic [2:0]  shamt;
  logic [15:0] src;
  logic [23:0] wide;
  logic [15:0] wr_data;
  logic [17:0] row18, row_off, wr_addr;

  assign coeff_ready = (state == S_RUN);
  assign issue       = (state == S_RUN && coeff_valid) || (state == S_ZFILL);
  assign last        = issue && (k == 6'd63);

  always_comb begin
    raster  = ZIGZAG[k];
    row     = raster[5:3];
    col     = raster[2:0];
    diag    = {1'b0, row} + {1'b0, col};
    shamt   = q_sel ? q1_shift(diag) : q0_shift(diag);
    src     = (state == S_RUN) ? coeff_data : 16'd0;
    wide    = {{8{src[15]}}, src} << shamt;
`ifdef DEQUANT_SAT_EN
    if ($signed(wide) > 24'sd32767)       wr_data = 16'h7FFF;
    else if ($signed(wide) < -24'sd32768) wr_data = 16'h8000;
    else                                  wr_data = wide[15:0];
`else
    wr_data = wide[15:0];
`endif
    // Row stride is 320 (Y) or 160 (U/V); built from shifts so no multiplier is needed.
    row18   = {15'd0, row};
    row_off = is_y ? (row18 << 8) + (row18 << 6) : (row18 << 7) + (row18 << 5);
    wr_addr = blk_base + row_off + {15'd0, col};
  end

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      k               <= '0;
      b               <= '0;
      q_sel           <= 1'b0;
      is_y            <= 1'b1;
      bcol            <= '0;
      blk_base        <= Y_BASE;
      row_base        <= Y_BASE;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      block_done      <= 1'b0;
      done            <= 1'b0;
    end else begin
      SRAM_we_n  <= !issue;
      block_done <= last;
      if (issue) begin
        SRAM_address    <= wr_addr;
        SRAM_write_data <= wr_data;
      end
      if (last) begin
        k     <= '0;
        b     <= b + 12'd1;
        state <= (b == 12'd2399) ? S_DONE : S_RUN;
        // Advance to the next block: region switch, next block row, or next block column.
        if (b == 12'd1199) begin
          blk_base <= U_BASE;
          row_base <= U_BASE;
          bcol     <= '0;
          is_y     <= 1'b0;
        end else if (b == 12'd1799) begin
          blk_base <= V_BASE;
          row_base <= V_BASE;
          bcol     <= '0;
        end else if (bcol == (is_y ? 6'd39 : 6'd19)) begin
          blk_base <= row_base + (is_y ? 18'd2560 : 18'd1280);
          row_base <= row_base + (is_y ? 18'd2560 : 18'd1280);
          bcol     <= '0;
        end else begin
          blk_base <= blk_base + 18'd8;
          bcol     <= bcol + 6'd1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            done <= 1'b0;
            if (Enable) begin
              state    <= S_RUN;
              k        <= '0;
              b        <= '0;
              q_sel    <= quant_sel;
              is_y     <= 1'b1;
              bcol     <= '0;
              blk_base <= Y_BASE;
              row_base <= Y_BASE;
            end
          end
          S_RUN: begin
            if (coeff_valid) begin
              k <= k + 6'd1;
              if (coeff_eob) state <= S_ZFILL;
            end
          end
          S_ZFILL: k <= k + 6'd1;
          S_DONE: begin
            // done rises one cycle after the final write and holds until Enable is low.
            done <= 1'b1;
            if (done && !Enable) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dequant_zigzag_writer.sv
// Directed self-checking bench for dequant_zigzag_writer: handshake, zero fill, addressing, done, saturation, reset.
module tb_dequant_zigzag_writer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic        quant_sel = 1'b0;
  logic        coeff_valid = 1'b0;
  logic        coeff_ready;
  logic [15:0] coeff_data = '0;
  logic        coeff_eob = 1'b0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        block_done;
  logic        done;

  int checks = 0;
  int failures = 0;

  dequant_zigzag_writer dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .quant_sel(quant_sel),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
    .coeff_eob(coeff_eob), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .block_done(block_done), .done(done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    coeff_valid = 1'b1;
    coeff_data  = d;
    coeff_eob   = e;
    @(negedge Clock);
  endtask

  task automatic expect_wr(input string tag, input logic [17:0] a, input logic [15:0] d);
    check({tag, "_we"}, 32'(SRAM_we_n), 32'd0);
    check({tag, "_addr"}, 32'(SRAM_address), 32'(a));
    check({tag, "_data"}, 32'(SRAM_write_data), 32'(d));
  endtask

  // Idles the input and follows the zero fill until block_done, bounded.
  task automatic drain(output int n_wr, output int n_nz, output int n_rdy,
                       output logic [17:0] second_a, output logic [17:0] last_a, output logic seen);
    n_wr = 0; n_nz = 0; n_rdy = 0; second_a = '0; last_a = '0; seen = 1'b0;
    coeff_valid = 1'b0;
    coeff_eob   = 1'b0;
    coeff_data  = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      if (!SRAM_we_n) begin
        n_wr++;
        if (SRAM_write_data != 16'd0) n_nz++;
        if (coeff_ready) n_rdy++;
        if (n_wr == 2) second_a = SRAM_address;
      end
      if (block_done) begin
        last_a = SRAM_address;
        seen   = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n_wr, n_nz, n_rdy, bad;
    logic [17:0] second_a, last_a, first_a;
    logic seen;

    repeat (2) @(negedge Clock);
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_data", 32'(SRAM_write_data), 32'd0);
    check("rst_ready", 32'(coeff_ready), 32'd0);
    check("rst_block_done", 32'(block_done), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);
    check("idle_ready", 32'(coeff_ready), 32'd0);

    // Block 0, Q0: 5, -3, 7+eob then zero fill.
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    check("run_ready", 32'(coeff_ready), 32'd1);
    push(16'd5, 1'b0);        expect_wr("b0_k0", 18'd76800, 16'd40);
    push(16'hFFFD, 1'b0);     expect_wr("b0_k1", 18'd76801, 16'hFFF4);
    push(16'd7, 1'b1);        expect_wr("b0_k2", 18'd77120, 16'd28);
    check("zfill_ready", 32'(coeff_ready), 32'd0);
    drain(n_wr, n_nz, n_rdy, second_a, last_a, seen);
    check("b0_done_seen", 32'(seen), 32'd1);
    check("b0_zero_writes", 32'(n_wr), 32'd61);
    check("b0_zero_data", 32'(n_nz), 32'd0);
    check("b0_ready_during_fill", 32'(n_rdy), 32'd1);
    check("b0_last_addr", 32'(last_a), 32'd79047);
    check("b1_ready", 32'(coeff_ready), 32'd1);

    // Block 1 with a 3-cycle stall after k=4.
    push(16'd1, 1'b0); expect_wr("b1_k0", 18'd76808, 16'd8);
    push(16'd1, 1'b0); expect_wr("b1_k1", 18'd76809, 16'd4);
    push(16'd1, 1'b0); expect_wr("b1_k2", 18'd77128, 16'd4);
    push(16'd1, 1'b0); expect_wr("b1_k3", 18'd77448, 16'd8);
    push(16'd1, 1'b0); expect_wr("b1_k4", 18'd77129, 16'd8);
    coeff_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("stall_we_n", 32'(SRAM_we_n), 32'd1);
    end
    push(16'd1, 1'b0); expect_wr("b1_k5", 18'd76810, 16'd8);
    push(16'd1, 1'b1); expect_wr("b1_k6", 18'd76811, 16'd16);
    drain(n_wr, n_nz, n_rdy, second_a, last_a, seen);
    check("b1_zero_writes", 32'(n_wr), 32'd57);
    check("b1_last_addr", 32'(last_a), 32'd79055);

    // Remaining blocks: zero data, eob at k=0.
    bad = 0;
    for (int blk = 2; blk < 2400; blk++) begin
      push(16'd0, 1'b1);
      first_a = SRAM_address;
      if (SRAM_we_n) bad++;
      drain(n_wr, n_nz, n_rdy, second_a, last_a, seen);
      if (!seen || n_wr != 63 || n_nz != 0) bad++;
      if (blk == 40)   check("b40_first", 32'(first_a), 32'd79360);
      if (blk == 1199) check("b1199_last", 32'(last_a), 32'd153599);
      if (blk == 1200) begin
        check("b1200_first", 32'(first_a), 32'd153600);
        check("b1200_row1", 32'(second_a), 32'd153760);
      end
      if (blk == 1800) check("b1800_first", 32'(first_a), 32'd192000);
      if (blk == 2399) begin
        check("b2399_last", 32'(last_a), 32'd230399);
        check("done_with_last_write", 32'(done), 32'd0);
      end
    end
    check("zero_blocks_bad", 32'(bad), 32'd0);
    @(negedge Clock);
    check("done_after_final", 32'(done), 32'd1);
    check("done_we_n", 32'(SRAM_we_n), 32'd1);

    Enable = 1'b1;
    repeat (3) @(negedge Clock);
    check("done_held_enable", 32'(done), 32'd1);
    check("done_ready", 32'(coeff_ready), 32'd0);
    Enable = 1'b0;
    @(negedge Clock);
    check("done_cleared", 32'(done), 32'd0);

    // Saturation / wrap at k=63 under Q0.
    quant_sel = 1'b0;
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    for (int i = 0; i < 63; i++) push(16'd0, 1'b0);
    push(16'd4096, 1'b0);
`ifdef DEQUANT_SAT_EN
    expect_wr("sat_k63", 18'd79047, 16'h7FFF);
`else
    expect_wr("sat_k63", 18'd79047, 16'h0000);
`endif
    check("sat_block_done", 32'(block_done), 32'd1);

    // Reset after 10 writes into block 1, then restart under Q1.
    for (int i = 0; i < 10; i++) push(16'd1, 1'b0);
    check("pre_reset_we_n", 32'(SRAM_we_n), 32'd0);
    Resetn = 1'b0;
    coeff_valid = 1'b0;
    #1;
    check("mid_reset_we_n", 32'(SRAM_we_n), 32'd1);
    check("mid_reset_ready", 32'(coeff_ready), 32'd0);
    @(negedge Clock);
    check("held_reset_we_n", 32'(SRAM_we_n), 32'd1);
    Resetn = 1'b1;
    @(negedge Clock);
    quant_sel = 1'b1;
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    quant_sel = 1'b0;
    push(16'hFFFF, 1'b0); expect_wr("q1_k0", 18'd76800, 16'hFFF8);
    push(16'd2, 1'b1);    expect_wr("q1_k1", 18'd76801, 16'd4);
    drain(n_wr, n_nz, n_rdy, second_a, last_a, seen);
    check("q1_zero_writes", 32'(n_wr), 32'd62);
    check("q1_last_addr", 32'(last_a), 32'd79047);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
